// File: rtl/regfile_wb_queue.sv
// In-order write-back queue feeding the integer register file write port, with RAW hazard flags.
// Optional macro REGFILE_WB_QUEUE_FORWARD_EN adds youngest-match forwarding data for rs1/rs2.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_wd,
  input  logic            wb_stall,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_wd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_pending,
  output logic            rs2_pending,
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
  output logic [XLEN-1:0] fwd1_data,
  output logic [XLEN-1:0] fwd2_data,
`endif
  output logic            empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [4:0]      rd_mem [DEPTH];
  logic [XLEN-1:0] wd_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [PW-1:0]   idx;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH)) && !rst;
  assign wb_en    = !empty && !wb_stall;
  assign wb_rd    = empty ? '0 : rd_mem[head];
  assign wb_wd    = empty ? '0 : wd_mem[head];

  // Writes to x0 are accepted but never occupy an entry.
  assign push = in_valid && in_ready && (in_rd != '0);
  assign pop  = wb_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage needs no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail] <= in_rd;
      wd_mem[tail] <= in_wd;
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    idx         = '0;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
    fwd1_data   = '0;
    fwd2_data   = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if ((rs1 != '0) && (rd_mem[idx] == rs1)) begin
          rs1_pending = 1'b1;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
          fwd1_data   = wd_mem[idx];
`endif
        end
        if ((rs2 != '0) && (rd_mem[idx] == rs2)) begin
          rs2_pending = 1'b1;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
          fwd2_data   = wd_mem[idx];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue: reset, latency, x0 drop, wrap, hazards, streaming.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_wd;
  logic        wb_stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        empty;
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
`endif

  regfile_wb_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wd(in_wd),
    .wb_stall(wb_stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad56 = 0;
  logic [36:0] wlog [$];
  int          wcyc [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs only change just after posedge, so negedge values are what the next edge commits.
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && wb_en) begin
      wlog.push_back({wb_rd, wb_wd});
      wcyc.push_back(cyc);
      if (wb_rd == 5'd5 || wb_rd == 5'd6) bad56++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int k, input logic [4:0] rd, input logic [31:0] wd);
    logic [36:0] e;
    e = (k < wlog.size()) ? wlog[k] : '1;
    check({tag, "_rd"}, 32'(e[36:32]), 32'(rd));
    check({tag, "_wd"}, e[31:0], wd);
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] wd);
    in_valid = 1'b1;
    in_rd    = rd;
    in_wd    = wd;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wd = '0;
    wb_stall = 1'b0; rs1 = '0; rs2 = '0;
    #1;
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_wd", wb_wd, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-queue discards everything
    wb_stall = 1'b1;
    push(5'd5, 32'hAAAA_0001);
    push(5'd6, 32'h0000_0002);
    rs1 = 5'd5;
    #1;
    check("mid_rs1_pending", 32'(rs1_pending), 32'd1);
    check("mid_empty", 32'(empty), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_wb_en", 32'(wb_en), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_rs1_pending", 32'(rs1_pending), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    #1;
    rst = 1'b0;
    wb_stall = 1'b0;
    rs1 = '0;
    step(); step(); step();
    check("arst_no_write", 32'(wlog.size()), 32'd0);
    check("arst_empty_after", 32'(empty), 32'd1);

    // Single write latency, no bypass
    wlog.delete(); wcyc.delete();
    in_valid = 1'b1; in_rd = 5'd3; in_wd = 32'hDEAD_BEEF;
    #1;
    check("lat_no_bypass", 32'(wb_en), 32'd0);
    step();
    in_valid = 1'b0;
    check("lat_wb_en", 32'(wb_en), 32'd1);
    check("lat_wb_rd", 32'(wb_rd), 32'd3);
    check("lat_wb_wd", wb_wd, 32'hDEAD_BEEF);
    step();
    check("lat_empty", 32'(empty), 32'd1);
    check("lat_wb_en_off", 32'(wb_en), 32'd0);
    check("lat_nwrites", 32'(wlog.size()), 32'd1);
    check_write("lat_w0", 0, 5'd3, 32'hDEAD_BEEF);

    // x0 writes are accepted and dropped
    in_valid = 1'b1; in_rd = 5'd0; in_wd = 32'hFFFF_FFFF;
    #1;
    check("x0_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("x0_empty", 32'(empty), 32'd1);
    check("x0_wb_en", 32'(wb_en), 32'd0);
    step();
    check("x0_nwrites", 32'(wlog.size()), 32'd1);

    // Fill under stall, then drain with wraparound
    wb_stall = 1'b1;
    for (int r = 1; r <= 4; r++) push(5'(r), 32'(100 + r));
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_wb_en", 32'(wb_en), 32'd0);
    wlog.delete(); wcyc.delete();
    wb_stall = 1'b0;
    in_valid = 1'b1; in_rd = 5'd7; in_wd = 32'd107;
    #1;
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    check("full_pop_wb_en", 32'(wb_en), 32'd1);
    step();
    check("refill_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("wrap_nwrites", 32'(wlog.size()), 32'd5);
    check_write("wrap_w0", 0, 5'd1, 32'd101);
    check_write("wrap_w1", 1, 5'd2, 32'd102);
    check_write("wrap_w2", 2, 5'd3, 32'd103);
    check_write("wrap_w3", 3, 5'd4, 32'd104);
    check_write("wrap_w4", 4, 5'd7, 32'd107);
    check("wrap_contig", 32'((wcyc.size() == 5) ? (wcyc[4] - wcyc[0]) : -1), 32'd4);
    check("wrap_empty", 32'(empty), 32'd1);

    // Hazard flags and same-rd ordering
    wb_stall = 1'b1;
    push(5'd9, 32'h11);
    push(5'd9, 32'h22);
    rs1 = 5'd9; rs2 = 5'd0;
    #1;
    check("haz_rs1", 32'(rs1_pending), 32'd1);
    check("haz_rs2_x0", 32'(rs2_pending), 32'd0);
`ifdef REGFILE_WB_QUEUE_FORWARD_EN
    check("haz_fwd1", fwd1_data, 32'h22);
    check("haz_fwd2", fwd2_data, 32'h0);
`endif
    rs2 = 5'd4;
    #1;
    check("haz_rs2_drained", 32'(rs2_pending), 32'd0);
    wlog.delete(); wcyc.delete();
    wb_stall = 1'b0;
    #1;
    check("haz_head_wd", wb_wd, 32'h11);
    check("haz_head_pending", 32'(rs1_pending), 32'd1);
    step();
    check("haz_after1_pending", 32'(rs1_pending), 32'd1);
    check("haz_after1_wd", wb_wd, 32'h22);
    step();
    check("haz_after2_pending", 32'(rs1_pending), 32'd0);
    check_write("haz_w0", 0, 5'd9, 32'h11);
    check_write("haz_w1", 1, 5'd9, 32'h22);
    rs1 = '0; rs2 = '0;

    // Simultaneous push/pop keeps occupancy at 2 with no bubbles
    wb_stall = 1'b1;
    push(5'd10, 32'd1);
    push(5'd11, 32'd2);
    wlog.delete(); wcyc.delete();
    wb_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_rd = 5'(12 + k); in_wd = 32'(3 + k);
      #1;
      check("pp_in_ready", 32'(in_ready), 32'd1);
      check("pp_wb_rd", 32'(wb_rd), 32'(10 + k));
      step();
    end
    in_valid = 1'b0;
    #1;
    check("pp_tail_wb_rd", 32'(wb_rd), 32'd14);
    step(); step();
    check("pp_empty", 32'(empty), 32'd1);
    check("pp_nwrites", 32'(wlog.size()), 32'd6);
    for (int k = 0; k < 6; k++) check_write("pp_w", k, 5'(10 + k), 32'(1 + k));
    check("pp_contig", 32'((wcyc.size() == 6) ? (wcyc[5] - wcyc[0]) : -1), 32'd5);

    check("never_x5_x6", 32'(bad56), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
